sobel_edge_y: RTL and testbench

Streaming 3×3 Sobel edge detector on the 8-bit luma/grey stream produced by the RGB565→YCbCr/grey stage. Uses two internal line buffers and a fixed-latency pipeline; outputs a binary edge map (0x00/0xFF) or passes luma through, with timing signals delayed to match. Sits between the colour-space stage and the frame-buffer write path.

---
 rtl/sobel_edge_y.sv | 146 ++++++++++++++
 tb/tb_sobel_edge_y.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sobel_edge_y.sv
// Streaming 3x3 Sobel edge detector on 8-bit luma with two line buffers.
// Five-stage pipeline; vsync/hsync/de are delayed to stay aligned with edge_data.
module sobel_edge_y #(
    parameter int unsigned IMG_W = 1280
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       edge_en,
    input  logic [7:0] thresh,
    input  logic       pre_frame_vsync,
    input  logic       pre_frame_hsync,
    input  logic       pre_frame_de,
    input  logic [7:0] img_y,
    output logic       post_frame_vsync,
    output logic       post_frame_hsync,
    output logic       post_frame_de,
    output logic [7:0] edge_data
);
    localparam int unsigned CW  = $clog2(IMG_W + 1);
    localparam int unsigned AW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned LAT = 5;

    logic [LAT-1:0]     r_vs, r_hs, r_de;
    logic [CW-1:0]      r_col;
    logic [1:0]         r_row;
    logic [7:0]         r_thr;
    logic               r_en;
    logic [7:0]         r_lb1 [IMG_W];
    logic [7:0]         r_lb2 [IMG_W];
    logic [7:0]         r_lb1_q, r_lb2_q;
    logic [3:0][7:0]    r_y;
    logic [3:0]         r_mask;
    logic [2:0][7:0]    r_w0, r_w1, r_w2;
    logic signed [10:0] r_gx, r_gy;
    logic [10:0]        r_mag;
    logic [7:0]         r_out;

    logic               w_vs_rise, w_de_fall, w_wr_en, w_mask;
    logic [CW-1:0]      w_pix_col;
    logic [1:0]         w_pix_row;
    logic [AW-1:0]      w_addr;
    logic [9:0]         w_sc, w_sl, w_st, w_sb;
    logic [10:0]        w_ax, w_ay, w_limit;

    // A frame start overrides the running counters for the pixel arriving with it
    assign w_vs_rise = pre_frame_vsync & ~r_vs[0];
    assign w_de_fall = ~pre_frame_de & r_de[0];
    assign w_pix_col = w_vs_rise ? '0 : r_col;
    assign w_pix_row = w_vs_rise ? '0 : r_row;
    assign w_wr_en   = pre_frame_de && (w_pix_col < CW'(IMG_W));
    assign w_addr    = AW'(w_pix_col);
    assign w_mask    = (w_pix_row < 2'd2) || (w_pix_col < CW'(2)) || (w_pix_col >= CW'(IMG_W));

    // Row/column counters and frame-stable control latches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
            r_thr <= '0;
            r_en  <= 1'b0;
        end else if (w_vs_rise) begin
            r_row <= '0;
            r_col <= pre_frame_de ? CW'(1) : '0;
            r_thr <= thresh;
            r_en  <= edge_en;
        end else if (w_de_fall) begin
            r_row <= (r_row == 2'd2) ? 2'd2 : r_row + 2'd1;
            r_col <= '0;
        end else if (pre_frame_de && (r_col != CW'(IMG_W))) begin
            r_col <= r_col + CW'(1);
        end
    end

    // Line buffer storage: LB1 takes the new pixel, LB2 takes LB1's previous line
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_lb1[w_addr] <= img_y;
            r_lb2[w_addr] <= r_lb1[w_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lb1_q <= '0;
            r_lb2_q <= '0;
        end else if (w_wr_en) begin
            r_lb1_q <= r_lb1[w_addr];
            r_lb2_q <= r_lb2[w_addr];
        end
    end

    // Column sums: newest column [0], oldest [2]; Gy is top row (p2) minus bottom row (p0)
    assign w_sc = 10'(r_w0[0]) + 10'({r_w1[0], 1'b0}) + 10'(r_w2[0]);
    assign w_sl = 10'(r_w0[2]) + 10'({r_w1[2], 1'b0}) + 10'(r_w2[2]);
    assign w_st = 10'(r_w2[2]) + 10'({r_w2[1], 1'b0}) + 10'(r_w2[0]);
    assign w_sb = 10'(r_w0[2]) + 10'({r_w0[1], 1'b0}) + 10'(r_w0[0]);

    assign w_ax    = r_gx[10] ? $unsigned(-r_gx) : $unsigned(r_gx);
    assign w_ay    = r_gy[10] ? $unsigned(-r_gy) : $unsigned(r_gy);
    assign w_limit = {1'b0, r_thr, 2'b00};

    // C1 input/LB read, C2 window shift, C3 gradients, C4 magnitude, C5 output mux
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs   <= '0;
            r_hs   <= '0;
            r_de   <= '0;
            r_y    <= '0;
            r_mask <= '0;
            r_w0   <= '0;
            r_w1   <= '0;
            r_w2   <= '0;
            r_gx   <= '0;
            r_gy   <= '0;
            r_mag  <= '0;
            r_out  <= '0;
        end else begin
            r_vs   <= {r_vs[LAT-2:0], pre_frame_vsync};
            r_hs   <= {r_hs[LAT-2:0], pre_frame_hsync};
            r_de   <= {r_de[LAT-2:0], pre_frame_de};
            r_y    <= {r_y[2:0], img_y};
            r_mask <= {r_mask[2:0], w_mask};
            if (r_de[0]) begin
                r_w0 <= {r_w0[1:0], r_y[0]};
                r_w1 <= {r_w1[1:0], r_lb1_q};
                r_w2 <= {r_w2[1:0], r_lb2_q};
            end
            r_gx  <= $signed({1'b0, w_sc}) - $signed({1'b0, w_sl});
            r_gy  <= $signed({1'b0, w_st}) - $signed({1'b0, w_sb});
            r_mag <= w_ax + w_ay;
            if (!r_de[3]) begin
                r_out <= 8'h00;
            end else if (r_en) begin
                r_out <= (r_mask[3] || !(r_mag > w_limit)) ? 8'h00 : 8'hFF;
            end else begin
                r_out <= r_y[3];
            end
        end
    end

    assign post_frame_vsync = r_vs[LAT-1];
    assign post_frame_hsync = r_hs[LAT-1];
    assign post_frame_de    = r_de[LAT-1];
    assign edge_data        = r_out;

endmodule

// File: tb/tb_sobel_edge_y.sv
// Directed bench for sobel_edge_y: every cycle compares {vsync,hsync,de,data}
// against the expected value of the input driven five cycles earlier.
module tb_sobel_edge_y;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       edge_en;
    logic [7:0] thresh;
    logic       pre_frame_vsync, pre_frame_hsync, pre_frame_de;
    logic [7:0] img_y;
    logic       post_frame_vsync, post_frame_hsync, post_frame_de;
    logic [7:0] edge_data;

    int          checks   = 0;
    int          failures = 0;
    logic [10:0] expq[$];
    string       tag;
    logic        lat_en;
    logic [7:0]  lat_thr;

    sobel_edge_y dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .edge_en          (edge_en),
        .thresh           (thresh),
        .pre_frame_vsync  (pre_frame_vsync),
        .pre_frame_hsync  (pre_frame_hsync),
        .pre_frame_de     (pre_frame_de),
        .img_y            (img_y),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_hsync (post_frame_hsync),
        .post_frame_de    (post_frame_de),
        .edge_data        (edge_data)
    );

    always #5 clk = ~clk;

    // Image kinds: 0 flat, 1 vertical step at col 10, 2 ramp, 3 horizontal step at row 1, 4 step at col 1280
    function automatic logic [7:0] pix(input int kind, input int r, input int c);
        case (kind)
            0:       return 8'h80;
            1:       return (c >= 10) ? 8'd200 : 8'd0;
            2:       return 8'(c);
            3:       return (r >= 1) ? 8'd200 : 8'd0;
            default: return (c >= 1280) ? 8'd200 : 8'd0;
        endcase
    endfunction

    // Hand-derived gradient magnitudes: a 0->200 step seen by the window gives 4*200 = 800
    function automatic logic [7:0] exp_px(input int kind, input int r, input int c);
        int gmag;
        if (!lat_en) return pix(kind, r, c);
        if (r < 2 || c < 2 || c >= 1280) return 8'h00;
        gmag = 0;
        if (kind == 1 && (c == 10 || c == 11)) gmag = 800;
        if (kind == 3 && r == 2) gmag = 800;
        return (gmag > 4 * int'(lat_thr)) ? 8'hFF : 8'h00;
    endfunction

    task automatic check_out(input logic [10:0] exp_v, input string name);
        logic [10:0] obs;
        obs = {post_frame_vsync, post_frame_hsync, post_frame_de, edge_data};
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp_v);
        end
    endtask

    task automatic step(input logic vs, input logic hs, input logic de,
                        input logic [7:0] y, input logic [7:0] ex);
        check_out(expq.pop_front(), tag);
        pre_frame_vsync = vs;
        pre_frame_hsync = hs;
        pre_frame_de    = de;
        img_y           = de ? y : 8'h00;
        expq.push_back({vs, hs, de, de ? ex : 8'h00});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic prefill();
        expq.delete();
        repeat (5) expq.push_back(11'd0);
    endtask

    task automatic frame_start(input logic en, input logic [7:0] thr, input string nm);
        tag     = nm;
        edge_en = en;
        thresh  = thr;
        lat_en  = en;
        lat_thr = thr;
        repeat (2) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        idle(3);
    endtask

    task automatic send_line(input int kind, input int r, input int nc);
        for (int c = 0; c < nc; c++) step(1'b0, 1'b0, 1'b1, pix(kind, r, c), exp_px(kind, r, c));
        repeat (2) step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        idle(2);
    endtask

    task automatic send_frame(input int kind, input logic en, input logic [7:0] thr,
                              input logic [7:0] thr_mid, input int nl, input int nc,
                              input string nm);
        frame_start(en, thr, nm);
        for (int r = 0; r < nl; r++) begin
            if (r == nl / 2) thresh = thr_mid;
            send_line(kind, r, nc);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        edge_en = 1'b0;
        thresh = 8'h00;
        pre_frame_vsync = 1'b0;
        pre_frame_hsync = 1'b0;
        pre_frame_de = 1'b0;
        img_y = 8'h00;
        lat_en = 1'b0;
        lat_thr = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_out(11'd0, "reset_state");
        rst_n = 1'b1;
        prefill();
        tag = "idle";
        idle(3);

        send_frame(0, 1'b1, 8'd10,  8'd10, 8, 16,   "flat");
        send_frame(1, 1'b1, 8'd50,  8'd50, 8, 16,   "vstep_t50");
        send_frame(1, 1'b1, 8'd255, 8'd50, 8, 16,   "vstep_t255_midchange");
        send_frame(1, 1'b1, 8'd50,  8'd50, 8, 16,   "vstep_after_vsync");
        send_frame(2, 1'b0, 8'd50,  8'd50, 8, 16,   "ramp_passthru");
        send_frame(3, 1'b1, 8'd50,  8'd50, 8, 16,   "hstep_border");
        send_frame(4, 1'b1, 8'd20,  8'd20, 3, 1283, "overlong_line");

        // Reset asserted in the middle of a line
        frame_start(1'b1, 8'd50, "pre_reset");
        for (int r = 0; r < 3; r++) send_line(1, r, 16);
        for (int c = 0; c < 12; c++) step(1'b0, 1'b0, 1'b1, pix(1, 3, c), exp_px(1, 3, c));
        pre_frame_de = 1'b0;
        img_y = 8'h00;
        rst_n = 1'b0;
        #1;
        check_out(11'd0, "async_reset");
        expq.delete();
        repeat (2) @(posedge clk);
        #1;
        check_out(11'd0, "reset_hold");
        rst_n = 1'b1;
        lat_en = 1'b0;
        lat_thr = 8'h00;
        prefill();
        tag = "post_reset_idle";
        idle(3);
        send_frame(1, 1'b1, 8'd50, 8'd50, 8, 16, "post_reset_frame");
        tag = "flush";
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
